// File: rtl/systolic_pkg.sv
// systolic_pkg: types and defaults shared by the
// systolic array and its input feeder.
package systolic_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int N_SIZE_DEF    = 3;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feed_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_input_feeder_if.sv
// systolic_input_feeder_if: row-pair valid/ready
// handshake into the feeder.
interface systolic_input_feeder_if #(
  parameter int DATAWIDTH = systolic_pkg::DATAWIDTH_DEF,
  parameter int N_SIZE    = systolic_pkg::N_SIZE_DEF
);

  logic                        s_valid;
  logic                        s_ready;
  logic [N_SIZE*DATAWIDTH-1:0] s_a_row;
  logic [N_SIZE*DATAWIDTH-1:0] s_b_row;

  modport master (
    output s_valid,
    output s_a_row,
    output s_b_row,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_a_row,
    input  s_b_row,
    output s_ready
  );

endinterface

// File: rtl/systolic_operand_bank.sv
// systolic_operand_bank: one A/B matrix pair,
// written by rows, read as A column / B row.
module systolic_operand_bank
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int N_SIZE    = N_SIZE_DEF,
  localparam int IW       = idx_w(N_SIZE),
  localparam int W        = N_SIZE*DATAWIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_row,
  input  logic [W-1:0]  wr_a,
  input  logic [W-1:0]  wr_b,
  input  logic [IW-1:0] rd_k,
  output logic [W-1:0]  rd_a,
  output logic [W-1:0]  rd_b
);

  logic [N_SIZE-1:0][W-1:0] a_q, a_d;
  logic [N_SIZE-1:0][W-1:0] b_q, b_d;

  // Row write port: one row of A and B per accept.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_en) begin
      a_d[wr_row] = wr_a;
      b_d[wr_row] = wr_b;
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Lane i of the A read is A[i][k]; B row k as stored.
  always_comb begin
    rd_a = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      rd_a[i*DATAWIDTH +: DATAWIDTH] =
        a_q[i][int'(rd_k)*DATAWIDTH +: DATAWIDTH];
    end
    rd_b = b_q[rd_k];
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: ping-pong operand buffer
// that streams k-beats into the systolic array.
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH    = DATAWIDTH_DEF,
  parameter int N_SIZE       = N_SIZE_DEF,
  parameter int DRAIN_CYCLES = 2*N_SIZE+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  systolic_input_feeder_if.slave      s,
  output logic [N_SIZE*DATAWIDTH-1:0] matrix_a_out,
  output logic [N_SIZE*DATAWIDTH-1:0] matrix_b_out,
  output logic                        valid_out,
  output logic                        busy
);

  localparam int W   = N_SIZE*DATAWIDTH;
  localparam int IW  = idx_w(N_SIZE);
  localparam int KW  = $clog2(N_SIZE+1);
  localparam int DCW = idx_w(DRAIN_CYCLES);
  localparam logic [IW-1:0] ROW_LAST = IW'(N_SIZE-1);
  localparam logic [KW-1:0] K_END    = KW'(N_SIZE);
  localparam logic [DCW-1:0] D_LAST  =
    DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES-1 : 0);

  feed_state_e    st_q, st_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           rd_bank_q, rd_bank_d;
  logic           wr_bank_q, wr_bank_d;
  logic [IW-1:0]  wr_row_q, wr_row_d;
  bank_state_e    bank_q [2];
  bank_state_e    bank_d [2];
  logic           valid_q, valid_d;
  logic [W-1:0]   mat_a_q, mat_a_d;
  logic [W-1:0]   mat_b_q, mat_b_d;

  logic           wr_fire;
  logic           rd_free;
  logic           start;
  logic           emit;
  logic [IW-1:0]  rd_idx;
  logic [W-1:0]   rd_a_all [2];
  logic [W-1:0]   rd_b_all [2];

  assign s.s_ready = (bank_q[wr_bank_q] != FULL);
  assign wr_fire   = s.s_valid && s.s_ready;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    systolic_operand_bank #(
      .DATAWIDTH(DATAWIDTH),
      .N_SIZE   (N_SIZE)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_fire && (wr_bank_q == 1'(g))),
      .wr_row(wr_row_q),
      .wr_a  (s.s_a_row),
      .wr_b  (s.s_b_row),
      .rd_k  (rd_idx),
      .rd_a  (rd_a_all[g]),
      .rd_b  (rd_b_all[g])
    );
  end

  // Write side: row counter, bank toggle, bank states.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    for (int i = 0; i < 2; i++) bank_d[i] = bank_q[i];
    if (wr_fire) begin
      if (wr_row_q == ROW_LAST) begin
        bank_d[wr_bank_q] = FULL;
        wr_row_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_row_d          = wr_row_q + 1'b1;
      end
    end
    if (rd_free) bank_d[rd_bank_q] = EMPTY;
  end

  // Read side: a new stream can start from IDLE, or
  // directly at the end of a drain / zero-length drain.
  always_comb begin
    st_d      = st_q;
    k_d       = k_q;
    dcnt_d    = dcnt_q;
    rd_bank_d = rd_bank_q;
    rd_free   = 1'b0;
    start     = 1'b0;
    emit      = 1'b0;
    unique case (st_q)
      IDLE: start = (bank_q[rd_bank_q] == FULL);
      STREAM: begin
        if (k_q != K_END) begin
          emit = 1'b1;
          k_d  = k_q + 1'b1;
        end else begin
          rd_free   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          if (DRAIN_CYCLES == 0) begin
            st_d  = IDLE;
            start = (bank_q[~rd_bank_q] == FULL);
          end else begin
            st_d   = DRAIN;
            dcnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          st_d  = IDLE;
          start = (bank_q[rd_bank_q] == FULL);
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
    rd_idx = start ? '0 : k_q[IW-1:0];
    if (start) begin
      st_d = STREAM;
      k_d  = KW'(1);
    end
    valid_d = start || emit;
    mat_a_d = valid_d ? rd_a_all[rd_bank_d] : '0;
    mat_b_d = valid_d ? rd_b_all[rd_bank_d] : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      k_q       <= '0;
      dcnt_q    <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      valid_q   <= 1'b0;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
    end else begin
      st_q      <= st_d;
      k_q       <= k_d;
      dcnt_q    <= dcnt_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      valid_q   <= valid_d;
      mat_a_q   <= mat_a_d;
      mat_b_q   <= mat_b_d;
    end
  end

  assign valid_out    = valid_q;
  assign matrix_a_out = mat_a_q;
  assign matrix_b_out = mat_b_q;
  assign busy         = (st_q != IDLE);

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb_systolic_input_feeder: random loads against a
// matrix-level schedule model, N=3 and N=5 builds.
module tb_systolic_input_feeder;

  localparam int DW   = 8;
  localparam int N0   = 3;
  localparam int D0   = 2*N0+1;
  localparam int N1   = 5;
  localparam int D1   = 0;
  localparam int NMAX = 5;
  localparam int WM   = NMAX*DW;
  localparam int MMAX = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_input_feeder_if #(.DATAWIDTH(DW), .N_SIZE(N0)) s0 ();
  systolic_input_feeder_if #(.DATAWIDTH(DW), .N_SIZE(N1)) s1 ();

  logic [N0*DW-1:0] a0, b0;
  logic             v0, busy0;
  logic [N1*DW-1:0] a1, b1;
  logic             v1, busy1;

  systolic_input_feeder #(
    .DATAWIDTH(DW), .N_SIZE(N0), .DRAIN_CYCLES(D0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s(s0),
    .matrix_a_out(a0), .matrix_b_out(b0),
    .valid_out(v0), .busy(busy0)
  );

  systolic_input_feeder #(
    .DATAWIDTH(DW), .N_SIZE(N1), .DRAIN_CYCLES(D1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1),
    .matrix_a_out(a1), .matrix_b_out(b1),
    .valid_out(v1), .busy(busy1)
  );

  bit          phase;
  int          n, drain;
  logic        in_v;
  logic [WM-1:0] in_a, in_b;

  assign s0.s_valid = in_v && (phase == 1'b0);
  assign s0.s_a_row = in_a[N0*DW-1:0];
  assign s0.s_b_row = in_b[N0*DW-1:0];
  assign s1.s_valid = in_v && (phase == 1'b1);
  assign s1.s_a_row = in_a[N1*DW-1:0];
  assign s1.s_b_row = in_b[N1*DW-1:0];

  logic          o_v, o_rdy, o_busy;
  logic [WM-1:0] o_a, o_b;

  always_comb begin
    if (phase == 1'b0) begin
      o_v = v0; o_rdy = s0.s_ready; o_busy = busy0;
      o_a = WM'(a0); o_b = WM'(b0);
    end else begin
      o_v = v1; o_rdy = s1.s_ready; o_busy = busy1;
      o_a = a1; o_b = b1;
    end
  end

  // Model: loaded matrices and the cycle each one's
  // beat 0 must appear, derived from the load times.
  logic [DW-1:0] ma [MMAX][NMAX][NMAX];
  logic [DW-1:0] mb [MMAX][NMAX][NMAX];
  int            S [MMAX];
  int            nmat, row, cyc, dir_m;
  bit            pend;
  logic [WM-1:0] pa, pb;

  logic [23:0] dir_a [3];
  logic [23:0] dir_b [3];
  logic [23:0] dir_ea [3];

  int cmps, errs;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    nmat = 0; row = 0; cyc = 0; dir_m = -1; pend = 1'b0;
  endtask

  task automatic step(input bit offer, input int pct,
                      input bit use_dir);
    logic          ev, ebusy, erdy;
    logic [WM-1:0] ea, eb;
    int            k, nxt;
    @(posedge clk);
    cyc++;
    if (pend && nmat < MMAX) begin
      for (int j = 0; j < n; j++) begin
        ma[nmat][row][j] = pa[j*DW +: DW];
        mb[nmat][row][j] = pb[j*DW +: DW];
      end
      row++;
      if (row == n) begin
        nxt = cyc + 1;
        if (nmat > 0 && S[nmat-1] + n + drain > nxt)
          nxt = S[nmat-1] + n + drain;
        S[nmat] = nxt;
        nmat++;
        row = 0;
      end
    end
    pend = 1'b0;
    #1;
    ev = 1'b0; ebusy = 1'b0; ea = '0; eb = '0;
    for (int m = 0; m < nmat; m++) begin
      if (cyc >= S[m] && cyc < S[m] + n) begin
        ev = 1'b1;
        k = cyc - S[m];
        for (int i = 0; i < n; i++) begin
          ea[i*DW +: DW] = ma[m][i][k];
          eb[i*DW +: DW] = mb[m][k][i];
        end
        if (m == dir_m) begin
          chk("dir_a", o_a, 64'(dir_ea[k]));
          chk("dir_b", o_b, 64'(dir_b[k]));
        end
      end
      if (cyc >= S[m] && cyc < S[m] + n + drain) ebusy = 1'b1;
    end
    erdy = 1'b1;
    if (nmat >= 2) erdy = (S[nmat-2] + n <= cyc);
    chk("valid", 64'(o_v), 64'(ev));
    chk("a_out", 64'(o_a), 64'(ea));
    chk("b_out", 64'(o_b), 64'(eb));
    chk("s_ready", 64'(o_rdy), 64'(erdy));
    chk("busy", 64'(o_busy), 64'(ebusy));
    in_a = WM'({$urandom(), $urandom()});
    in_b = WM'({$urandom(), $urandom()});
    if (use_dir) begin
      in_a = WM'(dir_a[row]);
      in_b = WM'(dir_b[row]);
    end
    in_v = offer && ($urandom_range(99) < pct);
    pend = in_v && erdy;
    pa = in_a;
    pb = in_b;
  endtask

  task automatic run(input int mats, input int pct,
                     input bit dir);
    int tgt, first, g;
    tgt = nmat + mats; first = nmat; g = 0;
    if (dir) dir_m = first;
    while (nmat < tgt && g < 3000) begin
      step(1'b1, pct, dir && (nmat == first));
      g++;
    end
    if (nmat < tgt) begin
      chk("load_timeout", 64'(nmat), 64'(tgt));
    end else begin
      while (cyc < S[tgt-1] + n + drain + 1 && g < 3000) begin
        step(1'b0, 0, 1'b0);
        g++;
      end
    end
    in_v = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(o_v), 64'(0));
    chk({tag, "_a"}, 64'(o_a), 64'(0));
    chk({tag, "_b"}, 64'(o_b), 64'(0));
    chk({tag, "_ready"}, 64'(o_rdy), 64'(1));
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_mid();
    int m, g;
    m = nmat; g = 0;
    while (nmat <= m && g < 500) begin
      step(1'b1, 100, 1'b0);
      g++;
    end
    if (nmat <= m) begin
      chk("mid_load_timeout", 64'(nmat), 64'(m+1));
    end else begin
      while (cyc < S[m] + 1 && g < 500) begin
        step(1'b1, 100, 1'b0);
        g++;
      end
    end
    rst_n = 1'b0; in_v = 1'b0;
    #1;
    reset_checks("mid_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cmps = 0; errs = 0;
    phase = 1'b0; n = N0; drain = D0;
    in_v = 1'b0; in_a = '0; in_b = '0;
    pa = '0; pb = '0;
    model_clear();
    dir_a[0] = 24'h030201; dir_a[1] = 24'h060504;
    dir_a[2] = 24'h090807;
    dir_b[0] = 24'h030102; dir_b[1] = 24'h070504;
    dir_b[2] = 24'h080906;
    dir_ea[0] = 24'h070401; dir_ea[1] = 24'h080502;
    dir_ea[2] = 24'h090603;
    do_reset();
    run(1, 100, 1'b1);
    run(3, 100, 1'b0);
    run(4, 45, 1'b0);
    reset_mid();
    run(1, 100, 1'b0);
    run(2, 70, 1'b0);
    phase = 1'b1; n = N1; drain = D1;
    do_reset();
    run(2, 100, 1'b0);
    run(3, 50, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, errs);
    $finish;
  end

endmodule
